vga_pixel_fetch: RTL

Upstream pixel source for the 800x600@72 Hz VGA timing generator. Streams a low-resolution 12-bit RGB framebuffer out of on-chip RAM through a prefetch FIFO, pixel-doubles it by SCALE in both axes, and hands one RGB word to the timing stage per active-pixel request. It absorbs RAM read latency so the timing stage sees a fixed one-cycle request-to-data delay.

---
 rtl/vga_pixel_fetch.sv | 131 +++++++++++++
 1 files changed

// File: rtl/vga_pixel_fetch.sv
// vga_pixel_fetch: framebuffer prefetch FIFO and SCALE-fold pixel doubler; VGA_PIX_FETCH_UFLOW_CNT_EN enables the underflow counter
module vga_pixel_fetch #(
  parameter int SRC_W  = 200,
  parameter int SRC_H  = 150,
  parameter int SCALE  = 4,
  parameter int ADDR_W = 15,
  parameter int RD_LAT = 2,
  parameter int DEPTH  = 16
) (
  input  logic              MAX10_CLK1_50,
  input  logic              reset,
  input  logic              frame_start,
  input  logic              pix_req,
  output logic [11:0]       pix_rgb,
  output logic              uflow,
  output logic [15:0]       uflow_cnt,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [11:0]       rd_data
);
  localparam int XW = SRC_W > 1 ? $clog2(SRC_W) : 1;
  localparam int VW = SRC_H * SCALE > 1 ? $clog2(SRC_H * SCALE) : 1;
  localparam int RW = SCALE > 1 ? $clog2(SCALE) : 1;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int IW = $clog2(RD_LAT + 1);
  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, DONE = 2'd2} state_t;
  state_t state, state_nxt;
  logic [XW-1:0] src_x;
  logic [VW-1:0] v;
  logic [RW-1:0] vrep, hrep;
  logic [ADDR_W-1:0] row_base;
  logic epoch;
  logic [RD_LAT-1:0] vld, ep;
  logic [IW-1:0] inflight;
  logic [11:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic last_x, last_rd, ret, push, pop, empty, starve;
  // read issue, FIFO handshakes and next state; a return is kept only if tagged with the live epoch
  always_comb begin
    state_nxt = state;
    rd_en = state == FETCH && 32'(count) + 32'(inflight) < 32'(DEPTH);
    rd_addr = row_base + ADDR_W'(src_x);
    last_x = src_x == XW'(SRC_W - 1);
    last_rd = rd_en && last_x && v == VW'(SRC_H * SCALE - 1);
    ret = vld[RD_LAT-1];
    push = ret && ep[RD_LAT-1] == epoch && !frame_start;
    empty = count == '0;
    starve = frame_start || empty;
    pop = pix_req && !starve && hrep == RW'(SCALE - 1);
    state_nxt = frame_start ? FETCH : last_rd ? DONE : state;
  end
  // state register
  always_ff @(posedge MAX10_CLK1_50) begin
    if (reset) state <= IDLE;
    else state <= state_nxt;
  end
  // incremental address walk: each source row is read SCALE times before the row base advances
  always_ff @(posedge MAX10_CLK1_50) begin
    if (reset || frame_start) begin
      src_x <= '0;
      v <= '0;
      vrep <= '0;
      row_base <= '0;
    end else if (rd_en) begin
      src_x <= last_x ? '0 : src_x + 1'b1;
      if (last_x) begin
        v <= last_rd ? '0 : v + 1'b1;
        vrep <= (last_rd || vrep == RW'(SCALE - 1)) ? '0 : vrep + 1'b1;
        row_base <= last_rd ? '0 : vrep == RW'(SCALE - 1) ? row_base + ADDR_W'(SRC_W) : row_base;
      end
    end
  end
  // read-latency pipeline tagged with the frame epoch; inflight counts every read not yet returned
  always_ff @(posedge MAX10_CLK1_50) begin
    if (reset) begin
      vld <= '0;
      ep <= '0;
      epoch <= 1'b0;
      inflight <= '0;
    end else begin
      vld[0] <= rd_en;
      ep[0] <= epoch;
      for (int i = 1; i < RD_LAT; i++) begin
        vld[i] <= vld[i-1];
        ep[i] <= ep[i-1];
      end
      epoch <= epoch ^ frame_start;
      inflight <= inflight + IW'(rd_en) - IW'(ret);
    end
  end
  // FIFO storage
  always_ff @(posedge MAX10_CLK1_50) begin
    if (push) mem[wr_ptr] <= rd_data;
  end
  // FIFO pointers and occupancy, flushed at frame start
  always_ff @(posedge MAX10_CLK1_50) begin
    if (reset || frame_start) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push);
      rd_ptr <= rd_ptr + PW'(pop);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  // pixel output: head repeated SCALE times, black plus uflow when starved or restarting
  always_ff @(posedge MAX10_CLK1_50) begin
    if (reset) begin
      pix_rgb <= 12'h000;
      uflow <= 1'b0;
      hrep <= '0;
    end else begin
      uflow <= pix_req && starve;
      if (frame_start) hrep <= '0;
      else if (pix_req && !empty) hrep <= hrep == RW'(SCALE - 1) ? '0 : hrep + 1'b1;
      if (pix_req) pix_rgb <= starve ? 12'h000 : mem[rd_ptr];
    end
  end
`ifdef VGA_PIX_FETCH_UFLOW_CNT_EN
  // saturating underflow event counter, cleared only by reset
  always_ff @(posedge MAX10_CLK1_50) begin
    if (reset) uflow_cnt <= 16'h0000;
    else if (uflow && uflow_cnt != 16'hFFFF) uflow_cnt <= uflow_cnt + 16'd1;
  end
`else
  assign uflow_cnt = 16'h0000;
`endif
endmodule
